// File: rtl/intersection_phase_scheduler.sv
// Phase scheduler for a two-road intersection: NS is the main road and EW is
// the side road. NS rests on green until EW demand or an NS pedestrian request
// forces a full cycle. Pedestrian WALK is shown at the start of a served green.
// Emergency preemption forces the requested direction to green and holds it.
module intersection_phase_scheduler #(
  parameter int GREEN_T  = 10,
  parameter int YELLOW_T = 3,
  parameter int ALLRED_T = 1,
  parameter int WALK_T   = 5,
  parameter int TW       = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       car_ew,
  input  logic       ped_ns,
  input  logic       ped_ew,
  input  logic       emerg_req,
  input  logic       emerg_dir,
  output logic [2:0] NS,
  output logic [2:0] EW,
  output logic       walk_ns,
  output logic       walk_ew,
  output logic       emerg_active,
  output logic [2:0] phase
);

  localparam logic [2:0] S_NS_GREEN     = 3'd0;
  localparam logic [2:0] S_NS_YELLOW    = 3'd1;
  localparam logic [2:0] S_RED_AFTER_NS = 3'd2;
  localparam logic [2:0] S_EW_GREEN     = 3'd3;
  localparam logic [2:0] S_EW_YELLOW    = 3'd4;
  localparam logic [2:0] S_RED_AFTER_EW = 3'd5;

  // Lamp encodings {Red, Yellow, Green}
  localparam logic [2:0] LAMP_RED    = 3'b100;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_GREEN  = 3'b001;

  localparam logic [TW-1:0] GREEN_LOAD  = TW'(GREEN_T - 1);
  localparam logic [TW-1:0] YELLOW_LOAD = TW'(YELLOW_T - 1);
  localparam logic [TW-1:0] ALLRED_LOAD = TW'(ALLRED_T - 1);
  localparam logic [TW-1:0] WALK_LOAD   = TW'(WALK_T);

  logic [2:0]    state;
  logic [2:0]    state_next;
  logic [TW-1:0] timer;
  logic [TW-1:0] timer_load;
  logic [TW-1:0] walk_ns_cnt;
  logic [TW-1:0] walk_ew_cnt;
  logic          ew_dem;
  logic          pns;
  logic          pew;
  logic          expired;
  logic          held;
  logic          enter_ns_green;
  logic          enter_ew_green;
  logic          entering;
  logic [2:0]    preempt_green;

  assign expired        = (timer == '0);
  assign preempt_green  = emerg_dir ? S_EW_GREEN : S_NS_GREEN;
  // Preempted direction is green: state and timer are frozen while requested.
  assign held           = emerg_req &&
                          (((state == S_NS_GREEN) && !emerg_dir) ||
                           ((state == S_EW_GREEN) &&  emerg_dir));
  assign entering       = (state_next != state);
  assign enter_ns_green = entering && (state_next == S_NS_GREEN);
  assign enter_ew_green = entering && (state_next == S_EW_GREEN);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_NS_GREEN;
    else       state <= state_next;
  end

  // Next-state: normal sequencing plus emergency abort, hold and redirect
  always_comb begin
    state_next = state;
    case (state)
      S_NS_GREEN: begin
        if (emerg_req && emerg_dir)        state_next = S_NS_YELLOW;
        else if (emerg_req)                state_next = S_NS_GREEN;
        else if (expired && (ew_dem || pns)) state_next = S_NS_YELLOW;
      end
      S_NS_YELLOW:    if (expired) state_next = S_RED_AFTER_NS;
      S_RED_AFTER_NS: if (expired) state_next = emerg_req ? preempt_green : S_EW_GREEN;
      S_EW_GREEN: begin
        if (emerg_req && !emerg_dir)       state_next = S_EW_YELLOW;
        else if (emerg_req)                state_next = S_EW_GREEN;
        else if (expired)                  state_next = S_EW_YELLOW;
      end
      S_EW_YELLOW:    if (expired) state_next = S_RED_AFTER_EW;
      S_RED_AFTER_EW: if (expired) state_next = emerg_req ? preempt_green : S_NS_GREEN;
      default:        state_next = S_NS_GREEN;
    endcase
  end

  // Duration reload for the state being entered
  always_comb begin
    timer_load = GREEN_LOAD;
    case (state_next)
      S_NS_YELLOW, S_EW_YELLOW:       timer_load = YELLOW_LOAD;
      S_RED_AFTER_NS, S_RED_AFTER_EW: timer_load = ALLRED_LOAD;
      default:                        timer_load = GREEN_LOAD;
    endcase
  end

  // Phase timer: reload on entry, freeze while held, otherwise count down to 0
  always_ff @(posedge clk or posedge reset) begin
    if (reset)              timer <= GREEN_LOAD;
    else if (entering)      timer <= timer_load;
    else if (!held && !expired) timer <= timer - 1'b1;
  end

  // Request latches; a new request wins over the clear on the same cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ew_dem <= 1'b0;
      pns    <= 1'b0;
      pew    <= 1'b0;
    end else begin
      ew_dem <= car_ew || ped_ew || (ew_dem && !enter_ew_green);
      pns    <= ped_ns || (pns && !enter_ns_green);
      pew    <= ped_ew || (pew && !enter_ew_green);
    end
  end

  // WALK counters: loaded on a served green entry, cancelled by any emergency
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      walk_ns_cnt <= '0;
      walk_ew_cnt <= '0;
    end else begin
      if (enter_ns_green)          walk_ns_cnt <= pns ? WALK_LOAD : '0;
      else if (emerg_req)          walk_ns_cnt <= '0;
      else if (walk_ns_cnt != '0)  walk_ns_cnt <= walk_ns_cnt - 1'b1;

      if (enter_ew_green)          walk_ew_cnt <= pew ? WALK_LOAD : '0;
      else if (emerg_req)          walk_ew_cnt <= '0;
      else if (walk_ew_cnt != '0)  walk_ew_cnt <= walk_ew_cnt - 1'b1;
    end
  end

  // Output decode: lamps from state, WALK gated off during any emergency
  always_comb begin
    NS = LAMP_RED;
    EW = LAMP_RED;
    case (state)
      S_NS_GREEN:  NS = LAMP_GREEN;
      S_NS_YELLOW: NS = LAMP_YELLOW;
      S_EW_GREEN:  EW = LAMP_GREEN;
      S_EW_YELLOW: EW = LAMP_YELLOW;
      default: begin
        NS = LAMP_RED;
        EW = LAMP_RED;
      end
    endcase
    walk_ns      = (state == S_NS_GREEN) && (walk_ns_cnt != '0) && !emerg_req;
    walk_ew      = (state == S_EW_GREEN) && (walk_ew_cnt != '0) && !emerg_req;
    emerg_active = held;
    phase        = state;
  end

endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// Bench for intersection_phase_scheduler: directed scenarios followed by
// randomized traffic, each cycle compared against a cycle-level reference model.
module tb_intersection_phase_scheduler;

  localparam int GREEN_T  = 10;
  localparam int YELLOW_T = 3;
  localparam int ALLRED_T = 1;
  localparam int WALK_T   = 5;
  localparam int TW       = 5;

  // Clock / reset block
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic car_ew = 1'b0, ped_ns = 1'b0, ped_ew = 1'b0;
  logic emerg_req = 1'b0, emerg_dir = 1'b0;
  logic [2:0] ns_lamp, ew_lamp, phase;
  logic walk_ns, walk_ew, emerg_active;

  always #5 clk = ~clk;

  intersection_phase_scheduler #(
    .GREEN_T(GREEN_T), .YELLOW_T(YELLOW_T), .ALLRED_T(ALLRED_T),
    .WALK_T(WALK_T), .TW(TW)
  ) dut (
    .clk(clk), .reset(reset), .car_ew(car_ew), .ped_ns(ped_ns), .ped_ew(ped_ew),
    .emerg_req(emerg_req), .emerg_dir(emerg_dir), .NS(ns_lamp), .EW(ew_lamp),
    .walk_ns(walk_ns), .walk_ew(walk_ew), .emerg_active(emerg_active), .phase(phase)
  );

  // Scoreboard
  int tests_run = 0;
  int tests_failed = 0;
  logic [11:0] exp_q[$];

  task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, observed, expected);
    end
  endtask

  // Reference model: phase index and cycles elapsed within that phase
  int m_ph, m_el, m_wns, m_wew;
  bit m_dem, m_pns, m_pew;

  function automatic int dur(input int ph);
    if (ph == 0 || ph == 3) return GREEN_T;
    if (ph == 1 || ph == 4) return YELLOW_T;
    return ALLRED_T;
  endfunction

  task automatic model_reset();
    m_ph = 0; m_el = 0; m_wns = 0; m_wew = 0;
    m_dem = 0; m_pns = 0; m_pew = 0;
  endtask

  // Expected {NS, EW, phase, walk_ns, walk_ew, emerg_active}
  function automatic logic [11:0] model_expect(input bit er, input bit ed);
    logic [2:0] ns, ew;
    bit held, wn, we;
    ns = (m_ph == 0) ? 3'b001 : (m_ph == 1) ? 3'b010 : 3'b100;
    ew = (m_ph == 3) ? 3'b001 : (m_ph == 4) ? 3'b010 : 3'b100;
    held = er && ((m_ph == 0 && !ed) || (m_ph == 3 && ed));
    wn = (m_ph == 0) && (m_wns > 0) && !er;
    we = (m_ph == 3) && (m_wew > 0) && !er;
    return {ns, ew, 3'(m_ph), wn, we, held};
  endfunction

  task automatic model_step(input bit c, input bit pn, input bit pe, input bit er, input bit ed);
    int  nph;
    bit  done, frozen, entered;
    int  mydir;
    nph = m_ph;
    frozen = 0;
    done = (m_el >= dur(m_ph) - 1);
    mydir = (m_ph == 3) ? 1 : 0;
    case (m_ph)
      0, 3: begin
        if (er && (int'(ed) != mydir)) nph = m_ph + 1;
        else if (er) frozen = 1;
        else if (done) begin
          if (m_ph == 3 || m_dem || m_pns) nph = m_ph + 1;
          else frozen = 1;
        end
      end
      1, 4: if (done) nph = m_ph + 1;
      default: if (done) nph = er ? (ed ? 3 : 0) : ((m_ph == 2) ? 3 : 0);
    endcase
    entered = (nph != m_ph);
    if (er) begin
      m_wns = 0; m_wew = 0;
    end else begin
      if (m_wns > 0) m_wns--;
      if (m_wew > 0) m_wew--;
    end
    if (entered && nph == 0) m_wns = m_pns ? WALK_T : 0;
    if (entered && nph == 3) m_wew = m_pew ? WALK_T : 0;
    m_dem = c || pe || (m_dem && !(entered && nph == 3));
    m_pns = pn || (m_pns && !(entered && nph == 0));
    m_pew = pe || (m_pew && !(entered && nph == 3));
    if (entered) m_el = 0;
    else if (!frozen) m_el++;
    m_ph = nph;
  endtask

  // Driver: apply one cycle of inputs, check outputs, advance the model
  task automatic run_cycle(input bit c, input bit pn, input bit pe, input bit er,
                           input bit ed, input bit rs);
    logic [11:0] e;
    @(negedge clk);
    car_ew = c; ped_ns = pn; ped_ew = pe; emerg_req = er; emerg_dir = ed; reset = rs;
    if (rs) model_reset();
    exp_q.push_back(model_expect(er, ed));
    #1;
    e = exp_q.pop_front();
    check("ns_lamp", 8'(ns_lamp), 8'(e[11:9]));
    check("ew_lamp", 8'(ew_lamp), 8'(e[8:6]));
    check("phase", 8'(phase), 8'(e[5:3]));
    check("walk_ns", 8'(walk_ns), 8'(e[2]));
    check("walk_ew", 8'(walk_ew), 8'(e[1]));
    check("emerg_active", 8'(emerg_active), 8'(e[0]));
    @(posedge clk);
    if (!rs) model_step(c, pn, pe, er, ed);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) run_cycle(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    bit er_r, ed_r, car_r;

    // Reset then idle: NS stays green
    model_reset();
    run_cycle(0, 0, 0, 0, 0, 1);
    run_cycle(0, 0, 0, 0, 0, 1);
    idle(40);

    // car_ew pulse at cycle 2 drives one full cycle
    run_cycle(0, 0, 0, 0, 0, 1);
    for (int k = 0; k < 34; k++) run_cycle(k == 2, 0, 0, 0, 0, 0);

    // ped_ew before the first EW green and again during it
    run_cycle(0, 0, 0, 0, 0, 1);
    for (int k = 0; k < 70; k++) run_cycle(0, k == 8, (k == 3) || (k == 16), 0, 0, 0);

    // Emergency toward EW raised during NS green, then released
    run_cycle(0, 0, 0, 0, 0, 1);
    for (int k = 0; k < 4; k++) run_cycle(0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 20; k++) run_cycle(0, 0, 0, 1, 1, 0);
    idle(40);

    // Emergency toward NS during EW yellow with a coincident car
    run_cycle(0, 0, 0, 0, 0, 1);
    for (int k = 0; k < 25; k++) run_cycle(k == 2, 0, 0, 0, 0, 0);
    run_cycle(1, 0, 0, 1, 0, 0);
    for (int k = 0; k < 20; k++) run_cycle(0, 0, 0, 1, 0, 0);
    idle(50);

    // Randomized traffic with emergencies and occasional reset
    er_r = 0; ed_r = 0; car_r = 0;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 39) == 0) er_r = !er_r;
      if ($urandom_range(0, 29) == 0) ed_r = !ed_r;
      if ($urandom_range(0, 14) == 0) car_r = !car_r;
      run_cycle(car_r, $urandom_range(0, 29) == 0, $urandom_range(0, 29) == 0,
                er_r, ed_r, $urandom_range(0, 399) == 0);
    end

    // Reset asserted during EW yellow
    idle(1);
    run_cycle(1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 100; k++) begin
      if (m_ph == 4) break;
      run_cycle(0, 1, 1, 0, 0, 0);
    end
    #1;
    check("reach_ew_yellow", 8'(phase), 8'd4);
    run_cycle(0, 0, 0, 0, 0, 1);
    idle(30);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/intersection_phase_scheduler.md
Name: intersection_phase_scheduler

Overview:
- Phase scheduler for a two-road intersection. NS is the main road and EW is the side road.
- Sequences NS and EW lamp groups through green, yellow and all-red phases with parameterised durations.
- Serves EW only on demand (car sensor or pedestrian button) and drives pedestrian WALK outputs.
- Handles emergency-vehicle preemption. Sits between sensor/button synchronisers and the lamp drivers.

Parameters:
- GREEN_T, 10, green phase length in cycles (≥2)
- YELLOW_T, 3, yellow phase length in cycles (≥1)
- ALLRED_T, 1, all-red clearance length in cycles (≥1)
- WALK_T, 5, WALK assertion length at start of a served green (1..GREEN_T)
- TW, 5, timer width in bits; must hold max(GREEN_T, WALK_T)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- car_ew  in  1  EW vehicle-present sensor, level, synchronous to clk
- ped_ns  in  1  NS pedestrian button pulse (≥1 cycle)
- ped_ew  in  1  EW pedestrian button pulse (≥1 cycle)
- emerg_req  in  1  emergency preemption request, level
- emerg_dir  in  1  preempted direction: 0 = NS, 1 = EW; valid while emerg_req high
- NS  out  3  {Red, Yellow, Green}, one-hot
- EW  out  3  {Red, Yellow, Green}, one-hot
- walk_ns  out  1  NS pedestrian WALK
- walk_ew  out  1  EW pedestrian WALK
- emerg_active  out  1  preempted direction currently green and being held
- phase  out  3  current state encoding, for debug/status

Behaviour:
- States (phase value): NS_GREEN=0, NS_YELLOW=1, RED_AFTER_NS=2, EW_GREEN=3, EW_YELLOW=4, RED_AFTER_EW=5. Codes 6–7 are unreachable and recover to NS_GREEN next cycle.
- Lamps (Moore decode of state):
  - NS_GREEN: NS=001, EW=100
  - NS_YELLOW: NS=010, EW=100
  - EW_GREEN: NS=100, EW=001
  - EW_YELLOW: NS=100, EW=010
  - Both RED_* states: NS=100, EW=100
  - NS and EW are never both non-red in the same cycle.
- Timer: on entry to a state with duration D, timer is loaded with D−1 and decrements each cycle. "Expire" means timer==0. Each state therefore lasts exactly D cycles unless held.
- Reset (asynchronous): state=NS_GREEN, timer=GREEN_T−1, all latches clear, walk counters clear. Outputs are NS=001, EW=100, walk_ns=0, walk_ew=0, emerg_active=0, phase=0.
- Request latches (set-dominant for the same-cycle set/clear case):
  - ew_dem is set by car_ew or ped_ew; cleared on entry to EW_GREEN.
  - pns is set by ped_ns; cleared on entry to NS_GREEN. pns is also set if ped_ns and the NS_GREEN entry coincide.
  - pew is set by ped_ew; cleared on entry to EW_GREEN.
- NS_GREEN:
  - On expiry, go to NS_YELLOW if ew_dem or pns is set; otherwise hold with timer at 0.
  - pns counts as demand so a waiting NS pedestrian forces a cycle.
- NS_YELLOW → RED_AFTER_NS on expiry.
- RED_AFTER_NS → EW_GREEN on expiry.
- EW_GREEN → EW_YELLOW on expiry, unconditionally.
- EW_YELLOW → RED_AFTER_EW on expiry.
- RED_AFTER_EW → NS_GREEN on expiry.
- WALK:
  - On entry to NS_GREEN with pns set, walk_ns is asserted for the first WALK_T cycles of that green.
  - On entry to EW_GREEN with pew set, walk_ew is asserted for the first WALK_T cycles of that green.
  - Both are forced to 0 while emerg_req=1 and never reasserted within that green.
- Emergency (emerg_req=1, direction d):
  - Green of the conflicting direction: go to its yellow on the next cycle, ignoring the remaining timer.
  - Green of d: timer frozen and the state held; emerg_active=1. When emerg_req falls, the timer resumes from its frozen value, but an NS_GREEN at 0 still needs demand to leave.
  - Yellow (either direction): always runs its full YELLOW_T; no abort.
  - RED_* on expiry: go to the green of d, regardless of normal sequence or ew_dem. This may re-enter the same direction. Entry reloads the timer and applies the latch clears.
  - emerg_dir changing while held: treated as a conflicting request next cycle.
- Reset asserted mid-phase returns to NS_GREEN immediately, including from yellow or all-red.

Test Plan:
- Reset release, no inputs for 40 cycles → NS=001/EW=100 throughout, phase=0, walks=0.
- car_ew pulse at cycle 2 → NS green until cycle 9, NS yellow cycles 10–12, all-red cycle 13, EW=001 cycles 14–23, EW yellow 24–26, all-red 27, NS green from 28.
- ped_ew pulse during NS_GREEN → walk_ew=1 for exactly 5 cycles at the start of EW_GREEN. A second ped_ew during that green → walk_ew again on the next EW_GREEN.
- emerg_req=1, emerg_dir=1 during NS_GREEN cycle 4 → NS_YELLOW at cycle 5 (3 cycles), RED_AFTER_NS 1 cycle, then EW_GREEN held with emerg_active=1 while the request is high. Release → 10-cycle remaining EW green resumes, then normal return to NS.
- emerg_req with emerg_dir=0 during EW_YELLOW → yellow completes, all-red, then NS_GREEN held. Simultaneous car_ew latches ew_dem, which is served after release.
- Reset asserted during EW_YELLOW → next sampled outputs NS=001, EW=100, phase=0, and all latches clear.
